// File: rtl/ddr_stream_writer_pkg.sv
// Shared types and constants for the DDR ring-buffer stream writer.
// The state enum, status word bit positions and a constant-safe clog2.
package ddr_stream_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam int STATUS_BUSY     = 0;
    localparam int STATUS_OVERFLOW = 1;
    localparam int STATUS_IRQ_WRAP = 2;
    localparam int STATUS_WRAP_LSB = 8;
    localparam int STATUS_WRAP_MSB = 15;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ddr_wr_fifo.sv
// Synchronous first-word-fall-through FIFO: the head entry is always visible
// on head_o, and the occupancy count is a plain register.
module ddr_wr_fifo
    import ddr_stream_writer_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk_i,
    input  logic                          srst_n_i,
    input  logic                          push_i,
    input  logic [DATA_W-1:0]             push_data_i,
    input  logic                          pop_i,
    output logic [DATA_W-1:0]             head_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [clog2(FIFO_DEPTH):0]    count_o
);
    localparam int PTR_W = clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q,  count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ddr_stream_writer.sv
// Stream-to-Avalon-MM burst writer filling a DDR ring buffer from a FIFO.
// Optional wrap interrupt and wrap counter: define DDR_STREAM_WRITER_WRAP_IRQ_EN.
module ddr_stream_writer
    import ddr_stream_writer_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 27,
    parameter int BURST_W    = 8,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [ADDR_W-1:0]     cfg_len_words,
    input  logic                  ctrl_enable,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    output logic [ADDR_W-1:0]     avm_address,
    output logic [BURST_W-1:0]    avm_burstcount,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic                  avm_write,
    input  logic                  avm_waitrequest,
    output logic [ADDR_W-1:0]     wr_offset,
    output logic [31:0]           status_word
);
    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_BURST = CNT_W'(BURST_LEN);

    state_e             state_q,  state_d;
    logic               stop_q,   stop_d;
    logic [ADDR_W-1:0]  base_q,   base_d;
    logic [ADDR_W-1:0]  len_q,    len_d;
    logic [ADDR_W-1:0]  offset_q, offset_d;
    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic [BURST_W-1:0] bcount_q, bcount_d;
    logic [BURST_W-1:0] beat_q,   beat_d;
    logic               write_q,  write_d;
    logic               ovf_q,    ovf_d;
`ifdef DDR_STREAM_WRITER_WRAP_IRQ_EN
    logic [7:0]         wrap_cnt_q, wrap_cnt_d;
    logic               irq_q,      irq_d;
`endif

    logic [DATA_W-1:0]  fifo_head;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               run, push, fire, last_beat, stopping;
    logic [ADDR_W-1:0]  offset_sum;

    // Accepting data requires a latched run: enable high, not idle, no pending stop.
    assign run        = ctrl_enable & (state_q != ST_IDLE) & ~stop_q;
    assign s_ready    = run & ~fifo_full;
    assign push       = s_valid & s_ready;
    assign fire       = write_q & ~avm_waitrequest;
    assign last_beat  = fire && (beat_q == bcount_q - BURST_W'(1));
    assign stopping   = stop_q | ~ctrl_enable;
    assign offset_sum = offset_q + ADDR_W'(bcount_q);

    ddr_wr_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_clk),
        .srst_n_i    (reset_reset_n),
        .push_i      (push),
        .push_data_i (s_data),
        .pop_i       (fire),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        stop_d   = stop_q;
        base_d   = base_q;
        len_d    = len_q;
        offset_d = offset_q;
        addr_d   = addr_q;
        bcount_d = bcount_q;
        beat_d   = beat_q;
        write_d  = write_q;
        ovf_d    = ovf_q | (run & s_valid & fifo_full);
`ifdef DDR_STREAM_WRITER_WRAP_IRQ_EN
        wrap_cnt_d = wrap_cnt_q;
        irq_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (ctrl_enable) begin
                    state_d  = ST_WAIT;
                    base_d   = cfg_base_addr;
                    len_d    = cfg_len_words;
                    offset_d = '0;
                    ovf_d    = 1'b0;
`ifdef DDR_STREAM_WRITER_WRAP_IRQ_EN
                    wrap_cnt_d = '0;
`endif
                end
            end
            ST_WAIT: begin
                stop_d = stopping;
                if (fifo_count >= FULL_BURST) begin
                    state_d  = ST_BURST;
                    addr_d   = base_q + offset_q;
                    bcount_d = BURST_W'(BURST_LEN);
                    beat_d   = '0;
                    write_d  = 1'b1;
                end else if (stopping && !fifo_empty) begin
                    state_d  = ST_FLUSH;
                    addr_d   = base_q + offset_q;
                    bcount_d = BURST_W'(fifo_count);
                    beat_d   = '0;
                    write_d  = 1'b1;
                end else if (stopping) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // Bursts always run to completion; an enable drop is only remembered.
                stop_d = stopping;
                if (last_beat) begin
                    write_d = 1'b0;
                    beat_d  = '0;
                    state_d = ST_WAIT;
                    if (offset_sum >= len_q) begin
                        offset_d = '0;
`ifdef DDR_STREAM_WRITER_WRAP_IRQ_EN
                        wrap_cnt_d = wrap_cnt_q + 8'd1;
                        irq_d      = 1'b1;
`endif
                    end else begin
                        offset_d = offset_sum;
                    end
                end else if (fire) begin
                    beat_d = beat_q + BURST_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q  <= ST_IDLE;
            stop_q   <= 1'b0;
            base_q   <= '0;
            len_q    <= '0;
            offset_q <= '0;
            addr_q   <= '0;
            bcount_q <= '0;
            beat_q   <= '0;
            write_q  <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef DDR_STREAM_WRITER_WRAP_IRQ_EN
            wrap_cnt_q <= '0;
            irq_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            stop_q   <= stop_d;
            base_q   <= base_d;
            len_q    <= len_d;
            offset_q <= offset_d;
            addr_q   <= addr_d;
            bcount_q <= bcount_d;
            beat_q   <= beat_d;
            write_q  <= write_d;
            ovf_q    <= ovf_d;
`ifdef DDR_STREAM_WRITER_WRAP_IRQ_EN
            wrap_cnt_q <= wrap_cnt_d;
            irq_q      <= irq_d;
`endif
        end
    end

    assign avm_address    = addr_q;
    assign avm_burstcount = bcount_q;
    assign avm_write      = write_q;
    assign avm_writedata  = write_q ? fifo_head : '0;
    assign avm_byteenable = {(DATA_W/8){write_q}};
    assign wr_offset      = offset_q;

    always_comb begin
        status_word = '0;
        status_word[STATUS_BUSY]     = (state_q != ST_IDLE);
        status_word[STATUS_OVERFLOW] = ovf_q;
`ifdef DDR_STREAM_WRITER_WRAP_IRQ_EN
        status_word[STATUS_IRQ_WRAP] = irq_q;
        status_word[STATUS_WRAP_MSB:STATUS_WRAP_LSB] = wrap_cnt_q;
`endif
    end

endmodule

// File: tb/tb_ddr_stream_writer.sv
// Self-checking bench for ddr_stream_writer: a queue-based model of the
// FIFO/ring plus directed scenarios with hand-computed burst expectations.
module tb_ddr_stream_writer;
    localparam int DW = 256, AW = 27, BW = 8, BL = 8, DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [AW-1:0]   cfg_base, cfg_len;
    logic            en, s_valid, s_ready;
    logic [DW-1:0]   s_data;
    logic [AW-1:0]   avm_address, wr_offset;
    logic [BW-1:0]   avm_burstcount;
    logic [DW-1:0]   avm_writedata;
    logic [DW/8-1:0] avm_byteenable;
    logic            avm_write, avm_waitrequest;
    logic [31:0]     status_word;

    ddr_stream_writer dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .cfg_base_addr   (cfg_base),
        .cfg_len_words   (cfg_len),
        .ctrl_enable     (en),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .avm_address     (avm_address),
        .avm_burstcount  (avm_burstcount),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_write       (avm_write),
        .avm_waitrequest (avm_waitrequest),
        .wr_offset       (wr_offset),
        .status_word     (status_word)
    );

    int errors = 0, checks = 0;
    logic [DW-1:0] q[$];
    int  base_m, len_m, off_m, wraps_m;
    bit  ovf_m, irq_m, run_m, mon_on, in_b, gap_req;
    int  exp_bc, beats, exp_addr;
    int  log_addr[$], log_bc[$];
    int  irq_pulses, cyc, pushes, push8_cyc, first_wr_cyc, stall_mode, next_k;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int k);
        return {8{32'(k) ^ 32'h5A5A0000}};
    endfunction

    initial begin
        avm_waitrequest = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (stall_mode)
                0:       avm_waitrequest = 1'b0;
                1:       avm_waitrequest = 1'($urandom_range(0, 1));
                default: avm_waitrequest = 1'b1;
            endcase
        end
    end

    // Model: queue of accepted beats is the FIFO; bursts drain it in order.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            in_b = 0; gap_req = 0; irq_m = 0; ovf_m = 0; wraps_m = 0; off_m = 0;
        end else begin
            if (gap_req) check("write_gap_after_burst", avm_write, 0);
            gap_req = 0;
            if (!en)        check("s_ready_disabled", s_ready, 0);
            else if (run_m) check("s_ready", s_ready, q.size() < DEPTH);
            if (mon_on) begin
                check("wr_offset", wr_offset, off_m);
                check("overflow", status_word[1], ovf_m);
`ifdef DDR_STREAM_WRITER_WRAP_IRQ_EN
                check("irq_wrap", status_word[2], irq_m);
                check("wrap_cnt", status_word[15:8], wraps_m % 256);
`else
                check("irq_wrap_off", status_word[2], 0);
                check("wrap_cnt_off", status_word[15:8], 0);
`endif
            end
            if (status_word[2]) irq_pulses++;
            irq_m = 0;
            if (run_m && s_valid && q.size() >= DEPTH) ovf_m = 1;
            if (avm_write) begin
                if (!in_b) begin
                    in_b = 1; beats = 0;
                    exp_bc = (q.size() < BL) ? q.size() : BL;
                    exp_addr = base_m + off_m;
                    log_addr.push_back(int'(avm_address));
                    log_bc.push_back(int'(avm_burstcount));
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                end
                check("avm_address", avm_address, exp_addr);
                check("avm_burstcount", avm_burstcount, exp_bc);
                check("avm_byteenable", avm_byteenable, {(DW/8){1'b1}});
                if (q.size() > 0) check("avm_writedata", avm_writedata, q[0]);
                else              check("write_with_empty_model", avm_write, 0);
                if (!avm_waitrequest && q.size() > 0) begin
                    void'(q.pop_front());
                    beats++;
                    if (beats == exp_bc) begin
                        in_b = 0; gap_req = 1;
                        $display("burst addr=0x%0h count=%0d", exp_addr, exp_bc);
                        if (off_m + exp_bc == len_m) begin
                            off_m = 0; wraps_m++; irq_m = 1;
                        end else begin
                            off_m += exp_bc;
                        end
                    end
                end
            end else if (in_b) begin
                check("write_held_in_burst", avm_write, 1);
            end
            if (s_valid && s_ready) begin
                q.push_back(s_data);
                pushes++;
                if (pushes == BL) push8_cyc = cyc;
            end
        end
    end

    task automatic start(input int base, input int len);
        mon_on = 0; run_m = 0;
        cfg_base = AW'(base); cfg_len = AW'(len); en = 1;
        @(posedge clk); #1;
        base_m = base; len_m = len; off_m = 0; wraps_m = 0; ovf_m = 0; irq_m = 0;
        log_addr.delete(); log_bc.delete();
        pushes = 0; first_wr_cyc = -1; push8_cyc = -100; irq_pulses = 0;
        run_m = 1; mon_on = 1;
        check("busy_after_enable", status_word[0], 1);
    endtask

    task automatic push_n(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            t = 0;
            s_valid = 1; s_data = mk(next_k);
            @(negedge clk);
            while (!s_ready && t < 2000) begin @(negedge clk); t++; end
            if (!s_ready) check("push_timeout", s_ready, 1);
            @(posedge clk); #1;
            next_k++;
        end
        s_valid = 0;
    endtask

    task automatic wait_bursts(input int n);
        int t;
        t = 0;
        while (!(log_addr.size() >= n && !in_b) && t < 3000) begin @(negedge clk); t++; end
        check("bursts_seen", log_addr.size(), n);
        @(posedge clk); #1;
    endtask

    task automatic stop_and_drain();
        int t;
        t = 0;
        en = 0; run_m = 0;
        @(negedge clk);
        while (status_word[0] && t < 3000) begin @(negedge clk); t++; end
        check("busy_after_stop", status_word[0], 0);
        check("fifo_drained", q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc;
        rst_n = 0; en = 0; s_valid = 0; s_data = '0; cfg_base = '0; cfg_len = '0;
        stall_mode = 0; next_k = 1; mon_on = 0; run_m = 0; first_wr_cyc = -1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_avm_write", avm_write, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_status", status_word, 0);
        check("rst_address", avm_address, 0);
        check("rst_burstcount", avm_burstcount, 0);
        check("rst_byteenable", avm_byteenable, 0);
        check("rst_wr_offset", wr_offset, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // 1: two full bursts, minimum latency
        start(32'h100, 32);
        push_n(16);
        wait_bursts(2);
        check("t1_addr0", log_addr[0], 32'h100);
        check("t1_addr1", log_addr[1], 32'h108);
        check("t1_bc0", log_bc[0], 8);
        check("t1_bc1", log_bc[1], 8);
        check("t1_offset", wr_offset, 16);
        check("t1_latency", first_wr_cyc - push8_cyc, 2);
        stop_and_drain();

        // 2: random stalls
        stall_mode = 1;
        start(32'h180, 64);
        push_n(24);
        wait_bursts(3);
        check("t2_addr2", log_addr[2], 32'h190);
        check("t2_bc2", log_bc[2], 8);
        check("t2_offset", wr_offset, 24);
        stall_mode = 0;
        stop_and_drain();

        // 3: 13 beats then enable drop -> 8 + flush of 5
        start(32'h200, 32);
        push_n(13);
        stop_and_drain();
        check("t3_nbursts", log_addr.size(), 2);
        check("t3_addr0", log_addr[0], 32'h200);
        check("t3_addr1", log_addr[1], 32'h208);
        check("t3_bc1", log_bc[1], 5);

        // 4: ring wrap
        start(32'h300, 16);
        push_n(40);
        wait_bursts(5);
        check("t4_addr2", log_addr[2], 32'h300);
        check("t4_addr3", log_addr[3], 32'h308);
        check("t4_addr4", log_addr[4], 32'h300);
`ifdef DDR_STREAM_WRITER_WRAP_IRQ_EN
        check("t4_wrap_cnt", status_word[15:8], 2);
        check("t4_irq_pulses", irq_pulses, 2);
`else
        check("t4_wrap_cnt_off", status_word[15:8], 0);
        check("t4_irq_pulses_off", irq_pulses, 0);
`endif
        stop_and_drain();

        // 5: slave stuck, overflow
        stall_mode = 2;
        start(32'h400, 128);
        acc = 0;
        s_valid = 1;
        for (int i = 0; i < 80; i++) begin
            s_data = mk(next_k);
            @(negedge clk);
            if (s_ready) begin acc++; next_k++; end
            @(posedge clk); #1;
        end
        s_valid = 0;
        check("t5_accepted", acc, 64);
        check("t5_s_ready_full", s_ready, 0);
        check("t5_overflow", status_word[1], 1);
        stall_mode = 0;
        stop_and_drain();
        check("t5_overflow_sticky", status_word[1], 1);
        start(32'h400, 128);
        check("t5_overflow_cleared", status_word[1], 0);
        stop_and_drain();

        // 6: reset mid-burst
        stall_mode = 1;
        start(32'h500, 32);
        push_n(10);
        acc = 0;
        while (!avm_write && acc < 200) begin @(posedge clk); #1; acc++; end
        check("t6_in_burst", avm_write, 1);
        rst_n = 0; en = 0; run_m = 0; mon_on = 0;
        @(posedge clk); #1;
        check("t6_avm_write", avm_write, 0);
        check("t6_s_ready", s_ready, 0);
        check("t6_status", status_word, 0);
        check("t6_wr_offset", wr_offset, 0);
        check("t6_address", avm_address, 0);
        rst_n = 1; stall_mode = 0;
        @(posedge clk); #1;
        start(32'h600, 32);
        push_n(3);
        stop_and_drain();
        check("t6_nbursts", log_addr.size(), 1);
        check("t6_flush_addr", log_addr[0], 32'h600);
        check("t6_flush_bc", log_bc[0], 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
